// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level mode and polarity, pending/enable state,
// registered CPU request (int_o, since int is reserved), claim register. Option: IRQ_CTRL_SWINT_EN.
module irq_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    output logic             int_o,
    output logic [5:0]       irq_id,
    input  logic             i_wb_cyc,
    input  logic [2:0]       addr,
    input  logic [31:0]      i_wb_data,
    input  logic             i_wb_we,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack
);

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_EN   = 3'd1;
    localparam logic [2:0] A_MODE = 3'd2;
    localparam logic [2:0] A_POL  = 3'd3;
    localparam logic [2:0] A_CLM  = 3'd4;
`ifdef IRQ_CTRL_SWINT_EN
    localparam logic [2:0] A_SWS  = 3'd5;
`endif

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pol_q, pol_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic             int_q, int_d;
    logic [5:0]       irq_id_q, irq_id_d;
    logic             ack_q, ack_d;

    logic [N_SRC-1:0] sync_out, lvl, set, clr, wdat, pe;
    logic             wr, rd;
    logic             unused_ok;

    function automatic logic [31:0] ext(input logic [N_SRC-1:0] v);
        ext = '0;
        ext[N_SRC-1:0] = v;
    endfunction

    assign unused_ok = &{1'b0, i_wb_data};
    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign wdat      = i_wb_data[N_SRC-1:0];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_src};

        wr = ack_q & i_wb_cyc & i_wb_we;
        rd = ack_q & i_wb_cyc & ~i_wb_we;

        enable_d = (wr && addr == A_EN)   ? wdat : enable_q;
        mode_d   = (wr && addr == A_MODE) ? wdat : mode_q;
        pol_d    = (wr && addr == A_POL)  ? wdat : pol_q;

        lvl = sync_out ^ pol_q;
        set = lvl & ~prev_q;
`ifdef IRQ_CTRL_SWINT_EN
        if (wr && addr == A_SWS)
            set = set | wdat;
`endif

        clr = '0;
        if (wr && addr == A_PEND)
            clr = wdat;
        if (rd && addr == A_CLM) begin
            for (int i = 0; i < N_SRC; i++)
                if (irq_id_q == 6'(i + 1))
                    clr[i] = 1'b1;
        end

        // A bit entering edge mode drops whatever the level path left behind.
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_d[i])
                pending_d[i] = (mode_q[i] & pending_q[i] & ~clr[i]) | set[i];
            else
                pending_d[i] = lvl[i];
        end

        // Reload with the new polarity so a polarity flip is never seen as an edge.
        prev_d = sync_out ^ pol_d;

        pe       = pending_q & enable_q;
        int_d    = |pe;
        irq_id_d = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (pe[i])
                irq_id_d = 6'(i + 1);

        ack_d = i_wb_cyc & ~ack_q;

        case (addr)
            A_PEND:  o_wb_rdt = ext(pending_q);
            A_EN:    o_wb_rdt = ext(enable_q);
            A_MODE:  o_wb_rdt = ext(mode_q);
            A_POL:   o_wb_rdt = ext(pol_q);
            A_CLM:   o_wb_rdt = {26'd0, irq_id_q};
            default: o_wb_rdt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
            prev_q    <= '0;
            int_q     <= 1'b0;
            irq_id_q  <= '0;
            ack_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            prev_q    <= prev_d;
            int_q     <= int_d;
            irq_id_q  <= irq_id_d;
            ack_q     <= ack_d;
        end
    end

    assign int_o    = int_q;
    assign irq_id   = irq_id_q;
    assign o_wb_ack = ack_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, register access, edge/level paths, claim, SWSET option.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        int_o;
    logic [5:0]  irq_id;
    logic        cyc;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdt;
    logic        ack;

    int vectors    = 0;
    int miscompares = 0;

    irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .int_o(int_o), .irq_id(irq_id),
        .i_wb_cyc(cyc), .addr(addr), .i_wb_data(wdata), .i_wb_we(we),
        .o_wb_rdt(rdt), .o_wb_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); cyc = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); @(posedge clk);
        @(negedge clk); cyc = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk); cyc = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1 d = rdt;
        @(posedge clk);
        @(negedge clk); cyc = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; irq_src = '0; cyc = 0; we = 0; addr = 0; wdata = 0;
        repeat (3) @(posedge clk);
        #1 vectors++;
        if ({int_o, irq_id, ack} !== 8'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %b want 0", {int_o, irq_id, ack});
        end
        @(negedge clk); rst = 1'b0;
        bus_wr(A(1), 32'hFF);
        bus_wr(A(2), 32'hFF);
        @(negedge clk); irq_src[3] = 1'b1;
        repeat (5) @(posedge clk);
        #1 vectors++;
        if (int_o !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset_int: got %b want 1", int_o);
        end
        @(negedge clk); irq_src[3] = 1'b0;
        // reset lands in the ack cycle of a POLARITY write
        @(negedge clk); cyc = 1'b1; we = 1'b1; addr = 3'd3; wdata = 32'hFF;
        @(posedge clk); #1 rst = 1'b1;
        #1 vectors++;
        if ({int_o, irq_id, ack} !== 8'd0) begin
            miscompares++; $display("FAIL midcycle_reset: got %b want 0", {int_o, irq_id, ack});
        end
        @(negedge clk); cyc = 1'b0; we = 1'b0; rst = 1'b0;
        for (int r = 0; r < 5; r++) begin
            bus_rd(3'(r), d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++; $display("FAIL reset_reg%0d: got %h want 0", r, d);
            end
        end
    endtask

    function automatic logic [2:0] A(input int a);
        return 3'(a);
    endfunction

    task automatic test_regs();
        logic [31:0] d;
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, d);
        vectors++;
        if (d !== 32'h0000_00FF) begin
            miscompares++; $display("FAIL enable_width: got %h want 000000ff", d);
        end
        bus_wr(3'd2, 32'h0000_00A5);
        bus_rd(3'd2, d);
        vectors++;
        if (d !== 32'h0000_00A5) begin
            miscompares++; $display("FAIL mode_rw: got %h want 000000a5", d);
        end
        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus_rd(3'd7, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++; $display("FAIL reserved7: got %h want 0", d);
        end
        bus_wr(3'd2, 32'hFF);
        bus_wr(3'd1, 32'hFF);
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        @(negedge clk); addr = 3'd0; irq_src[3] = 1'b1;
        @(posedge clk); @(posedge clk); #1 vectors++;
        if (rdt !== 32'd0) begin
            miscompares++; $display("FAIL pend_edge2: got %h want 0", rdt);
        end
        @(posedge clk); #1 vectors++;
        if (rdt !== 32'h08 || int_o !== 1'b0) begin
            miscompares++; $display("FAIL pend_edge3: got %h/%b want 08/0", rdt, int_o);
        end
        @(posedge clk); #1 vectors++;
        if (int_o !== 1'b1 || irq_id !== 6'd4) begin
            miscompares++; $display("FAIL int_edge4: got %b/%0d want 1/4", int_o, irq_id);
        end
        @(negedge clk); irq_src[3] = 1'b0;
        bus_rd(3'd4, d);
        vectors++;
        if (d !== 32'd4) begin
            miscompares++; $display("FAIL claim_src3: got %0d want 4", d);
        end
        @(posedge clk); #1 vectors++;
        if (int_o !== 1'b0 || irq_id !== 6'd0) begin
            miscompares++; $display("FAIL post_claim: got %b/%0d want 0/0", int_o, irq_id);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        @(negedge clk); irq_src[5] = 1'b1; irq_src[2] = 1'b1;
        repeat (5) @(posedge clk);
        bus_rd(3'd4, d);
        vectors++;
        if (d !== 32'd3) begin
            miscompares++; $display("FAIL claim_first: got %0d want 3", d);
        end
        @(posedge clk); #1 vectors++;
        if (irq_id !== 6'd6 || int_o !== 1'b1) begin
            miscompares++; $display("FAIL after_claim1: got %0d/%b want 6/1", irq_id, int_o);
        end
        bus_rd(3'd4, d);
        vectors++;
        if (d !== 32'd6) begin
            miscompares++; $display("FAIL claim_second: got %0d want 6", d);
        end
        @(posedge clk); #1 vectors++;
        if (int_o !== 1'b0) begin
            miscompares++; $display("FAIL after_claim2: got %b want 0", int_o);
        end
        @(negedge clk); irq_src[5] = 1'b0; irq_src[2] = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_level();
        logic [31:0] d;
        bus_wr(3'd2, 32'hFD);
        @(negedge clk); irq_src[1] = 1'b1;
        repeat (5) @(posedge clk);
        bus_wr(3'd0, 32'h02);
        @(posedge clk); #1 vectors++;
        if (int_o !== 1'b1) begin
            miscompares++; $display("FAIL level_w1c_int: got %b want 1", int_o);
        end
        bus_rd(3'd0, d);
        vectors++;
        if (d !== 32'h02) begin
            miscompares++; $display("FAIL level_pending: got %h want 02", d);
        end
        @(negedge clk); irq_src[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 vectors++;
        if (int_o !== 1'b1) begin
            miscompares++; $display("FAIL level_drop3: got %b want 1", int_o);
        end
        @(posedge clk); #1 vectors++;
        if (int_o !== 1'b0) begin
            miscompares++; $display("FAIL level_drop4: got %b want 0", int_o);
        end
        bus_wr(3'd2, 32'hFF);
    endtask

    task automatic test_set_wins_and_polarity();
        logic [31:0] d;
        @(negedge clk); irq_src[0] = 1'b1;
        @(posedge clk);
        // write acks on edge 2 and commits on edge 3, the edge-detect cycle
        bus_wr(3'd0, 32'h01);
        bus_rd(3'd0, d);
        vectors++;
        if (d !== 32'h01) begin
            miscompares++; $display("FAIL set_wins: got %h want 01", d);
        end
        bus_wr(3'd0, 32'h01);
        bus_rd(3'd0, d);
        vectors++;
        if (d !== 32'h00) begin
            miscompares++; $display("FAIL w1c_edge: got %h want 00", d);
        end
        @(negedge clk); irq_src[0] = 1'b0;
        repeat (4) @(posedge clk);
        bus_wr(3'd3, 32'h01);
        repeat (4) @(posedge clk);
        bus_rd(3'd0, d);
        vectors++;
        if (d !== 32'h00 || int_o !== 1'b0) begin
            miscompares++; $display("FAIL pol_no_edge: got %h/%b want 00/0", d, int_o);
        end
        bus_wr(3'd3, 32'h00);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_swset();
        logic [31:0] d;
        bus_wr(3'd1, 32'h80);
        bus_wr(3'd5, 32'h80);
        bus_rd(3'd5, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++; $display("FAIL swset_read: got %h want 0", d);
        end
`ifdef IRQ_CTRL_SWINT_EN
        vectors++;
        if (int_o !== 1'b1) begin
            miscompares++; $display("FAIL swset_int: got %b want 1", int_o);
        end
        bus_rd(3'd4, d);
        vectors++;
        if (d !== 32'd8) begin
            miscompares++; $display("FAIL swset_claim: got %0d want 8", d);
        end
`else
        bus_rd(3'd0, d);
        vectors++;
        if (d !== 32'd0 || int_o !== 1'b0) begin
            miscompares++; $display("FAIL swset_absent: got %h/%b want 0/0", d, int_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_edge_latency();
        test_priority();
        test_level();
        test_set_wins_and_polarity();
        test_swset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
